// File: rtl/step_ctrl.sv
// rtl/step_ctrl.sv - push-button single-step / run-N / free-run controller with PC breakpoint
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset
//   btn        raw push-button (asynchronous, bouncy)
//   mode       00 STEP, 01 RUN_N, 10 FREE, 11 HALT
//   run_count  number of steps for RUN_N
//   bp_en      breakpoint enable
//   bp_addr    breakpoint PC
//   pc         current core PC
//   step_en    core advance enable
//   running    high while in RUN
//   bp_hit     high while in HALTED
//   retired    count of step_en cycles (wraps)
module step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int PC_WIDTH        = 32,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn,
    input  logic [1:0]           mode,
    input  logic [CNT_WIDTH-1:0] run_count,
    input  logic                 bp_en,
    input  logic [PC_WIDTH-1:0]  bp_addr,
    input  logic [PC_WIDTH-1:0]  pc,
    output logic                 step_en,
    output logic                 running,
    output logic                 bp_hit,
    output logic [31:0]          retired
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] MODE_STEP = 2'b00;
    localparam logic [1:0] MODE_RUNN = 2'b01;
    localparam logic [1:0] MODE_FREE = 2'b10;
    localparam logic [1:0] MODE_HALT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_RUN,
        S_HALTED
    } state_t;

    logic [1:0]           sync_q;
    logic                 db_level;
    logic                 db_prev;
    logic [DB_W-1:0]      db_cnt;
    logic                 press;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                 unlimited_q, unlimited_d;
    logic                 step_raw;
    logic                 bp_match;

    // Synchronizer and debouncer. The counter only runs while the synchronized
    // level disagrees with the accepted level, so any bounce back clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= 2'b00;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            db_prev <= db_level;
            if (sync_q[1] != db_level) begin
                if (db_cnt == DB_LAST) begin
                    db_level <= sync_q[1];
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press    = db_level & ~db_prev;
    assign bp_match = bp_en && (pc == bp_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            unlimited_q <= 1'b0;
            retired     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            unlimited_q <= unlimited_d;
            if (step_en) begin
                retired <= retired + 32'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unlimited_d = unlimited_q;
        step_raw    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press) begin
                    case (mode)
                        MODE_STEP: state_d = S_STEP;
                        MODE_RUNN: begin
                            if (run_count != '0) begin
                                state_d     = S_RUN;
                                remaining_d = run_count;
                                unlimited_d = 1'b0;
                            end
                        end
                        MODE_FREE: begin
                            state_d     = S_RUN;
                            unlimited_d = 1'b1;
                        end
                        MODE_HALT: state_d = S_IDLE;
                        default:   state_d = S_IDLE;
                    endcase
                end
            end
            S_STEP: begin
                step_raw = 1'b1;
                state_d  = S_IDLE;
            end
            S_RUN: begin
                // Breakpoint beats press beats HALT; none of them retire an instruction.
                if (bp_match) begin
                    state_d = S_HALTED;
                end else if (press || (mode == MODE_HALT)) begin
                    state_d = S_IDLE;
                end else begin
                    step_raw = 1'b1;
                    if (!unlimited_q) begin
                        remaining_d = remaining_q - CNT_WIDTH'(1);
                        if (remaining_q == CNT_WIDTH'(1)) begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_HALTED: begin
                if (press) begin
                    state_d = S_STEP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Gated by rst so a reset mid-run stops the core in the same cycle.
    assign step_en = step_raw & rst;
    assign running = (state_q == S_RUN);
    assign bp_hit  = (state_q == S_HALTED);

endmodule

// File: tb/tb_step_ctrl.sv
// tb/tb_step_ctrl.sv - scoreboard testbench for step_ctrl
module tb_step_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn;
    logic [1:0]  mode;
    logic [15:0] run_count;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        step_en;
    logic        running;
    logic        bp_hit;
    logic [31:0] retired;
    logic        pc_clr;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [31:0] pc;
        logic        run;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_ret = 32'd0;

    step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .PC_WIDTH(32),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .mode(mode),
        .run_count(run_count),
        .bp_en(bp_en),
        .bp_addr(bp_addr),
        .pc(pc),
        .step_en(step_en),
        .running(running),
        .bp_hit(bp_hit),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // Core model: PC advances by 4 on every enabled cycle.
    always @(posedge clk) begin
        if (pc_clr) pc <= 32'd0;
        else if (step_en) pc <= pc + 32'd4;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] p, input logic r);
        exp_t e;
        e.pc  = p;
        e.run = r;
        e.ret = exp_ret;
        sb.push_back(e);
        exp_ret = exp_ret + 32'd1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input bit on_bp, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = on_bp ? bp_hit : step_en;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic clr_pc();
        pc_clr = 1'b1;
        tick(1);
        pc_clr = 1'b0;
    endtask

    // Monitor: every enabled cycle must match the next expected step.
    always @(negedge clk) begin
        if (step_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_step_en", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("step_pc", pc, e.pc);
                chk("step_running", {31'd0, running}, {31'd0, e.run});
                chk("step_retired", retired, e.ret);
            end
        end
    end

    initial begin
        rst = 1'b0; btn = 1'b0; mode = 2'b00; run_count = 16'd0;
        bp_en = 1'b0; bp_addr = 32'd0; pc_clr = 1'b1;
        tick(3);
        chk("rst_step_en", {31'd0, step_en}, 32'd0);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        rst = 1'b1;
        pc_clr = 1'b0;
        tick(2);

        // Bouncy press in STEP mode: one step only.
        push_exp(32'd0, 1'b0);
        btn = 1'b1; tick(2);
        btn = 1'b0; tick(2);
        btn = 1'b1; tick(10);
        btn = 1'b0; tick(12);
        chk("bounce_retired", retired, 32'd1);
        chk("bounce_running", {31'd0, running}, 32'd0);

        // RUN_N with 5 steps.
        clr_pc();
        mode = 2'b01; run_count = 16'd5;
        for (int i = 0; i < 5; i++) push_exp(32'(i * 4), 1'b1);
        btn = 1'b1;
        wait_for(1'b0, "runn_start");
        for (int i = 0; i < 5; i++) begin
            chk("runn_step_en", {31'd0, step_en}, 32'd1);
            chk("runn_running", {31'd0, running}, 32'd1);
            @(negedge clk);
        end
        chk("runn_end_step_en", {31'd0, step_en}, 32'd0);
        chk("runn_end_running", {31'd0, running}, 32'd0);
        tick(1);
        btn = 1'b0; tick(12);
        chk("runn_retired", retired, 32'd6);

        // RUN_N with zero count: press ignored.
        run_count = 16'd0;
        btn = 1'b1; tick(12);
        btn = 1'b0; tick(12);
        chk("zero_retired", retired, 32'd6);
        chk("zero_running", {31'd0, running}, 32'd0);

        // FREE run into breakpoint at 0x10.
        clr_pc();
        mode = 2'b10; bp_en = 1'b1; bp_addr = 32'h10;
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4), 1'b1);
        btn = 1'b1;
        wait_for(1'b1, "bp_reached");
        chk("bp_pc", pc, 32'h10);
        chk("bp_running", {31'd0, running}, 32'd0);
        tick(1);
        btn = 1'b0; tick(12);
        chk("bp_hold", {31'd0, bp_hit}, 32'd1);
        chk("bp_retired", retired, 32'd10);

        // Press from HALTED: single step past the breakpoint.
        push_exp(32'h10, 1'b0);
        btn = 1'b1; tick(12);
        btn = 1'b0; tick(12);
        chk("resume_pc", pc, 32'h14);
        chk("resume_bp_hit", {31'd0, bp_hit}, 32'd0);
        chk("resume_running", {31'd0, running}, 32'd0);
        chk("resume_retired", retired, 32'd11);
        bp_en = 1'b0;

        // FREE run aborted by HALT after 3 steps.
        clr_pc();
        mode = 2'b10;
        for (int i = 0; i < 3; i++) push_exp(32'(i * 4), 1'b1);
        btn = 1'b1;
        wait_for(1'b0, "halt_start");
        tick(1); tick(1); tick(1);
        mode = 2'b11;
        @(negedge clk);
        chk("halt_step_en", {31'd0, step_en}, 32'd0);
        chk("halt_running_same", {31'd0, running}, 32'd1);
        @(negedge clk);
        chk("halt_running_next", {31'd0, running}, 32'd0);
        tick(1);
        btn = 1'b0; tick(12);
        chk("halt_retired", retired, 32'd14);

        // Reset mid-run drops step_en at once; btn held across reset gives one press.
        clr_pc();
        mode = 2'b10;
        for (int i = 0; i < 2; i++) push_exp(32'(i * 4), 1'b1);
        btn = 1'b1;
        wait_for(1'b0, "mrst_start");
        tick(1); tick(1);
        rst = 1'b0;
        #1;
        chk("mrst_step_en", {31'd0, step_en}, 32'd0);
        chk("mrst_running", {31'd0, running}, 32'd0);
        chk("mrst_retired", retired, 32'd0);
        mode = 2'b00;
        exp_ret = 32'd0;
        clr_pc();
        push_exp(32'd0, 1'b0);
        tick(2);
        rst = 1'b1;
        tick(15);
        btn = 1'b0; tick(12);
        chk("postrst_retired", retired, 32'd1);
        chk("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
